// File: rtl/tinycrypt_pkg.sv
// Shared constants for the tinycrypt block cipher engine: register map,
// status bit positions, FSM states and direction encoding.
package tinycrypt_pkg;

  localparam logic [7:0] ADDR_K0     = 8'h00;
  localparam logic [7:0] ADDR_K1     = 8'h04;
  localparam logic [7:0] ADDR_K2     = 8'h08;
  localparam logic [7:0] ADDR_K3     = 8'h0C;
  localparam logic [7:0] ADDR_DELTA  = 8'h10;
  localparam logic [7:0] ADDR_ROUNDS = 8'h14;
  localparam logic [7:0] ADDR_STATUS = 8'h18;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_ERR  = 1;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Configuration registers that are locked while a block is in flight.
  function automatic logic cfg_addr(input logic [7:0] a);
    return (a == ADDR_K0) || (a == ADDR_K1) || (a == ADDR_K2) ||
           (a == ADDR_K3) || (a == ADDR_DELTA) || (a == ADDR_ROUNDS);
  endfunction

endpackage

// File: rtl/tinycrypt_if.sv
// Block stream handshake plus APB-style register port of tinycrypt.
interface tinycrypt_if #(
  parameter int unsigned W = 16
);
  logic           req;
  logic           mode;
  logic [2*W-1:0] din;
  logic           ready;
  logic           done;
  logic [2*W-1:0] dout;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [7:0]     paddr;
  logic [31:0]    pwdata;
  logic [31:0]    prdata;
  logic           pready;

  modport master (
    output req, mode, din, psel, penable, pwrite, paddr, pwdata,
    input  ready, done, dout, prdata, pready
  );

  modport slave (
    input  req, mode, din, psel, penable, pwrite, paddr, pwdata,
    output ready, done, dout, prdata, pready
  );
endinterface

// File: rtl/tinycrypt_round.sv
// One combinational TEA-style round, encrypt or decrypt, on W-bit halves.
module tinycrypt_round
  import tinycrypt_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned SHL = 4,
  parameter int unsigned SHR = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] sum,
  input  logic [W-1:0] delta,
  input  logic [W-1:0] k0,
  input  logic [W-1:0] k1,
  input  logic [W-1:0] k2,
  input  logic [W-1:0] k3,
  input  logic         mode,
  output logic [W-1:0] x_n,
  output logic [W-1:0] y_n,
  output logic [W-1:0] sum_n
);

  function automatic logic [W-1:0] f(input logic [W-1:0] v, input logic [W-1:0] ka,
                                     input logic [W-1:0] kb, input logic [W-1:0] s);
    return ((v << SHL) + ka) ^ (v + s) ^ ((v >> SHR) + kb);
  endfunction

  logic [W-1:0] sum_up;
  logic [W-1:0] x_enc;
  logic [W-1:0] y_dec;

  // Encrypt updates sum first and chains x into y; decrypt undoes that in reverse.
  always_comb begin
    sum_up = sum + delta;
    x_enc  = x + f(y, k0, k1, sum_up);
    y_dec  = y - f(x, k2, k3, sum);
    if (mode == MODE_ENC) begin
      x_n   = x_enc;
      y_n   = y + f(x_enc, k2, k3, sum_up);
      sum_n = sum_up;
    end else begin
      y_n   = y_dec;
      x_n   = x - f(y_dec, k0, k1, sum);
      sum_n = sum - delta;
    end
  end

endmodule

// File: rtl/tinycrypt.sv
// TEA-style block cipher engine: FSM, round counter, working snapshots and
// the APB-style configuration register file.
module tinycrypt
  import tinycrypt_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter logic [63:0] KEY    = 64'h816f_c52b_09e7_4da3,
  parameter logic [15:0] DELTA  = 16'h1,
  parameter int unsigned SHL    = 4,
  parameter int unsigned SHR    = 5,
  parameter logic [7:0]  ROUNDS = 8'd1
) (
  input  logic      clk,
  input  logic      rst,
  tinycrypt_if.slave bus
);

  localparam logic [W-1:0] K0_RST    = W'(KEY[15:0]);
  localparam logic [W-1:0] K1_RST    = W'(KEY[31:16]);
  localparam logic [W-1:0] K2_RST    = W'(KEY[47:32]);
  localparam logic [W-1:0] K3_RST    = W'(KEY[63:48]);
  localparam logic [W-1:0] DELTA_RST = W'(DELTA);

  state_t state_q, state_d;

  logic [W-1:0] k0_q, k1_q, k2_q, k3_q, delta_q;
  logic [7:0]   rounds_q;
  logic         err_q;
  logic [31:0]  prdata_q;

  logic [W-1:0] wk0, wk1, wk2, wk3, wdelta;
  logic [W-1:0] x_q, y_q, sum_q;
  logic [7:0]   cnt_q;
  logic         mode_q;
  logic [2*W-1:0] dout_q;

  logic [W-1:0] x_n, y_n, sum_n;
  logic busy, accept;
  logic wr_en, rd_en, err_set, cfg_wr;
  logic [31:0] rd_data;
  logic unused_pwdata;

  assign busy   = (state_q == ST_RUN);
  assign accept = bus.req && !busy;

  assign bus.dout    = dout_q;
  assign bus.prdata  = prdata_q;
  assign bus.pready  = 1'b1;
  assign unused_pwdata = ^bus.pwdata;

  tinycrypt_round #(.W(W), .SHL(SHL), .SHR(SHR)) u_round (
    .x(x_q), .y(y_q), .sum(sum_q), .delta(wdelta),
    .k0(wk0), .k1(wk1), .k2(wk2), .k3(wk3), .mode(mode_q),
    .x_n(x_n), .y_n(y_n), .sum_n(sum_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = (rounds_q == '0) ? ST_DONE : ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN:  if (cnt_q == 8'd1) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b1;
    bus.done  = 1'b0;
    case (state_q)
      ST_RUN:  bus.ready = 1'b0;
      ST_DONE: bus.done  = 1'b1;
      default: ;
    endcase
  end

  // Accept snapshots the config registers so mid-flight writes cannot disturb a block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; sum_q <= '0; cnt_q <= '0; mode_q <= MODE_ENC;
      wk0 <= '0; wk1 <= '0; wk2 <= '0; wk3 <= '0; wdelta <= '0;
      dout_q <= '0;
    end else if (accept) begin
      x_q    <= bus.din[W-1:0];
      y_q    <= bus.din[2*W-1:W];
      mode_q <= bus.mode;
      wk0 <= k0_q; wk1 <= k1_q; wk2 <= k2_q; wk3 <= k3_q;
      wdelta <= delta_q;
      cnt_q  <= rounds_q;
      sum_q  <= (bus.mode == MODE_DEC) ? delta_q * W'(rounds_q) : '0;
      if (rounds_q == '0) dout_q <= bus.din;
    end else if (busy) begin
      x_q   <= x_n;
      y_q   <= y_n;
      sum_q <= sum_n;
      cnt_q <= cnt_q - 8'd1;
      if (cnt_q == 8'd1) dout_q <= {y_n, x_n};
    end
  end

  assign wr_en   = bus.psel && bus.penable && bus.pwrite;
  assign rd_en   = bus.psel && !bus.penable;
  assign err_set = wr_en && cfg_addr(bus.paddr) && busy;
  assign cfg_wr  = wr_en && cfg_addr(bus.paddr) && !busy;

  always_comb begin
    rd_data = '0;
    case (bus.paddr)
      ADDR_K0:     rd_data = 32'(k0_q);
      ADDR_K1:     rd_data = 32'(k1_q);
      ADDR_K2:     rd_data = 32'(k2_q);
      ADDR_K3:     rd_data = 32'(k3_q);
      ADDR_DELTA:  rd_data = 32'(delta_q);
      ADDR_ROUNDS: rd_data = 32'(rounds_q);
      ADDR_STATUS: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_ERR]  = err_q;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k0_q <= K0_RST; k1_q <= K1_RST; k2_q <= K2_RST; k3_q <= K3_RST;
      delta_q  <= DELTA_RST;
      rounds_q <= ROUNDS;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      if (rd_en) prdata_q <= rd_data;
      // A fresh error outranks the clear-on-read of status.
      if (err_set)                                  err_q <= 1'b1;
      else if (rd_en && bus.paddr == ADDR_STATUS)   err_q <= 1'b0;
      if (cfg_wr) begin
        case (bus.paddr)
          ADDR_K0:     k0_q     <= bus.pwdata[W-1:0];
          ADDR_K1:     k1_q     <= bus.pwdata[W-1:0];
          ADDR_K2:     k2_q     <= bus.pwdata[W-1:0];
          ADDR_K3:     k3_q     <= bus.pwdata[W-1:0];
          ADDR_DELTA:  delta_q  <= bus.pwdata[W-1:0];
          ADDR_ROUNDS: rounds_q <= bus.pwdata[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tinycrypt.sv
// Scoreboarded bench for tinycrypt at W=16, with W=8 and W=32 round-trip copies.
module tb_tinycrypt;
  import tinycrypt_pkg::*;

  localparam int SHL = 4;
  localparam int SHR = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tinycrypt_if #(.W(8))  bus8();
  tinycrypt_if #(.W(16)) bus16();
  tinycrypt_if #(.W(32)) bus32();

  tinycrypt #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  tinycrypt #(.W(16)) dut   (.clk(clk), .rst(rst), .bus(bus16));
  tinycrypt #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  logic [2:0]  req_v, mode_v, ready_v, done_v;
  logic [63:0] din_v [3];
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  assign bus8.req  = req_v[0]; assign bus8.mode  = mode_v[0]; assign bus8.din  = din_v[0][15:0];
  assign bus16.req = req_v[1]; assign bus16.mode = mode_v[1]; assign bus16.din = din_v[1][31:0];
  assign bus32.req = req_v[2]; assign bus32.mode = mode_v[2]; assign bus32.din = din_v[2];
  assign bus8.psel = psel;  assign bus8.penable = penable;  assign bus8.pwrite = pwrite;
  assign bus8.paddr = paddr;  assign bus8.pwdata = pwdata;
  assign bus16.psel = psel; assign bus16.penable = penable; assign bus16.pwrite = pwrite;
  assign bus16.paddr = paddr; assign bus16.pwdata = pwdata;
  assign bus32.psel = psel; assign bus32.penable = penable; assign bus32.pwrite = pwrite;
  assign bus32.paddr = paddr; assign bus32.pwdata = pwdata;
  assign ready_v = {bus32.ready, bus16.ready, bus8.ready};
  assign done_v  = {bus32.done, bus16.done, bus8.done};

  typedef struct {
    int          which;
    logic [63:0] exp;
    int          acc;
    int          rounds;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] kw [4];
  logic [31:0] dw;
  int          rw;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int which);
    return (which == 0) ? 8 : (which == 1) ? 16 : 32;
  endfunction

  function automatic logic [63:0] dout_of(input int which);
    if (which == 0) return 64'(bus8.dout);
    if (which == 1) return 64'(bus16.dout);
    return 64'(bus32.dout);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic longint unsigned rf(input longint unsigned v, input longint unsigned ka,
                                         input longint unsigned kb, input longint unsigned s,
                                         input longint unsigned m);
    return ((((v << SHL) & m) + ka) ^ (v + s) ^ ((v >> SHR) + kb)) & m;
  endfunction

  // Reference cipher: the running sum at round i is simply i*delta.
  function automatic logic [63:0] model(input int w, input bit dec, input logic [63:0] blk,
                                        input int rounds);
    longint unsigned m, x, y, s, d, k0, k1, k2, k3;
    m  = (64'd1 << w) - 64'd1;
    x  = blk & m;
    y  = (blk >> w) & m;
    d  = 64'(dw) & m;
    k0 = 64'(kw[0]) & m; k1 = 64'(kw[1]) & m; k2 = 64'(kw[2]) & m; k3 = 64'(kw[3]) & m;
    if (!dec) begin
      for (int i = 1; i <= rounds; i++) begin
        s = (longint'(i) * d) & m;
        x = (x + rf(y, k0, k1, s, m)) & m;
        y = (y + rf(x, k2, k3, s, m)) & m;
      end
    end else begin
      for (int i = rounds; i >= 1; i--) begin
        s = (longint'(i) * d) & m;
        y = (y - rf(x, k2, k3, s, m)) & m;
        x = (x - rf(y, k0, k1, s, m)) & m;
      end
    end
    return (y << w) | x;
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    d = bus16.prdata;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2,
                     input logic [31:0] k3, input logic [31:0] d, input int r);
    apb_write(ADDR_K0, k0); apb_write(ADDR_K1, k1);
    apb_write(ADDR_K2, k2); apb_write(ADDR_K3, k3);
    apb_write(ADDR_DELTA, d); apb_write(ADDR_ROUNDS, 32'(r));
    kw[0] = k0; kw[1] = k1; kw[2] = k2; kw[3] = k3; dw = d; rw = r;
  endtask

  // Called at posedge+1; acc is the cycle in which req && ready is presented.
  task automatic send(input int which, input bit dec, input logic [63:0] blk,
                      input logic [63:0] exp, input bit hold, input bit track, output int acc);
    exp_t e;
    int n;
    acc = -1;
    req_v[which] = 1'b1; mode_v[which] = dec; din_v[which] = blk;
    n = 0;
    while (!ready_v[which] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_v[which]) begin
      total++; bad++;
      $display("FAIL accept_timeout: actual=ready low expected=ready high");
      req_v[which] = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk); #1;
    if (track) begin
      e.which = which; e.exp = exp; e.acc = acc; e.rounds = rw;
      sb.push_back(e);
    end
    if (!hold) req_v[which] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done: actual=done on inst %0d expected=no done", i);
          end else begin
            e = sb.pop_front();
            check("done_inst", 64'(i), 64'(e.which));
            check("dout", dout_of(i), e.exp);
            check("latency", 64'(cyc - e.acc), 64'(e.rounds + 1));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [63:0] blk, ct;
    int a0, a1, a2, c0;
    logic busy_exp;

    rst = 1'b1;
    req_v = '0; mode_v = '0;
    for (int i = 0; i < 3; i++) din_v[i] = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    kw[0] = 32'h4da3; kw[1] = 32'h09e7; kw[2] = 32'hc52b; kw[3] = 32'h816f; dw = 32'h1; rw = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 64'(bus16.ready), 64'd1);
    check("rst_done", 64'(bus16.done), 64'd0);
    check("rst_dout", 64'(bus16.dout), 64'd0);
    check("rst_prdata", 64'(bus16.prdata), 64'd0);
    apb_read(ADDR_K0, rd);     check("rst_k0", 64'(rd), 64'h4da3);
    apb_read(ADDR_K3, rd);     check("rst_k3", 64'(rd), 64'h816f);
    apb_read(ADDR_DELTA, rd);  check("rst_delta", 64'(rd), 64'h1);
    apb_read(ADDR_ROUNDS, rd); check("rst_rounds", 64'(rd), 64'h1);
    apb_read(ADDR_STATUS, rd); check("rst_status", 64'(rd), 64'h0);
    apb_read(8'h1C, rd);       check("unmapped_rd", 64'(rd), 64'h0);

    cfg(32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 1);
    send(1, 1'b0, 64'h0, 64'h0012_0001, 1'b0, 1'b1, a0);
    drain();
    send(1, 1'b1, 64'h0012_0001, 64'h0, 1'b0, 1'b1, a0);
    drain();

    cfg($urandom, $urandom, $urandom, $urandom, $urandom, 32);
    for (int i = 0; i < 100; i++) begin
      blk = 64'($urandom);
      ct  = model(16, 1'b0, blk, rw);
      send(1, 1'b0, blk, ct, 1'b0, 1'b1, a0);
      send(1, 1'b1, ct, blk, 1'b0, 1'b1, a0);
    end
    drain();

    cfg(kw[0], kw[1], kw[2], kw[3], dw, 0);
    send(1, 1'b0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1'b1, a0);
    check("ready_pass", 64'(bus16.ready), 64'd1);
    drain();

    cfg(kw[0], kw[1], kw[2], kw[3], dw, 8);
    blk = 64'($urandom);
    send(1, 1'b0, blk, model(16, 1'b0, blk, rw), 1'b0, 1'b1, a0);
    apb_write(ADDR_K0, 32'h1234);
    c0 = cyc; busy_exp = (c0 >= a0 + 1) && (c0 <= a0 + rw);
    apb_read(ADDR_STATUS, rd);
    check("status_err", 64'(rd), {62'd0, 1'b1, busy_exp});
    c0 = cyc; busy_exp = (c0 >= a0 + 1) && (c0 <= a0 + rw);
    apb_read(ADDR_STATUS, rd);
    check("status_clr", 64'(rd), {62'd0, 1'b0, busy_exp});
    apb_read(ADDR_K0, rd);
    check("k0_locked", 64'(rd), 64'(kw[0][15:0]));
    drain();

    cfg(kw[0], kw[1], kw[2], kw[3], dw, 4);
    blk = 64'($urandom); send(1, 1'b0, blk, model(16, 1'b0, blk, rw), 1'b1, 1'b1, a0);
    blk = 64'($urandom); send(1, 1'b1, blk, model(16, 1'b1, blk, rw), 1'b1, 1'b1, a1);
    blk = 64'($urandom); send(1, 1'b0, blk, model(16, 1'b0, blk, rw), 1'b0, 1'b1, a2);
    check("b2b_gap1", 64'(a1 - a0), 64'd5);
    check("b2b_gap2", 64'(a2 - a1), 64'd5);
    drain();

    cfg(kw[0], kw[1], kw[2], kw[3], dw, 8);
    send(1, 1'b0, 64'($urandom), 64'h0, 1'b0, 1'b0, a0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 64'(bus16.ready), 64'd1);
    check("abort_dout", 64'(bus16.dout), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    kw[0] = 32'h4da3; kw[1] = 32'h09e7; kw[2] = 32'hc52b; kw[3] = 32'h816f; dw = 32'h1; rw = 1;
    apb_read(ADDR_K0, rd);    check("abort_k0", 64'(rd), 64'h4da3);
    apb_read(ADDR_DELTA, rd); check("abort_delta", 64'(rd), 64'h1);

    cfg($urandom, $urandom, $urandom, $urandom, $urandom, 32);
    for (int w = 0; w < 3; w += 2) begin
      for (int i = 0; i < 10; i++) begin
        blk = {$urandom, $urandom};
        blk = blk & ((64'd1 << (2 * wid(w))) - 64'd1);
        if (w == 2) blk = {$urandom, $urandom};
        ct = model(wid(w), 1'b0, blk, rw);
        send(w, 1'b0, blk, ct, 1'b0, 1'b1, a0);
        send(w, 1'b1, ct, blk, 1'b0, 1'b1, a0);
      end
      drain();
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinycrypt.md
Name: tinycrypt

Overview:
- Parametrised successor to the fixed-mode TEA-style decrypt core.
- Width-generic TEA-style block cipher engine: W-bit half-words, 2W-bit blocks, four W-bit subkeys.
- Direction (encrypt/decrypt) selected per request; round count is runtime-programmable.
- Sits between a streaming req/ready producer and a consumer. Key, delta and rounds are configured through an APB-style register port on the same clock.

Parameters:
- W, 16, half-word width; legal values 8, 16, 32.
- KEY, 64'h816fc52b09e74da3, reset subkeys {k3,k2,k1,k0}, each the low W bits of the matching 16-bit field, zero-extended when W=32.
- DELTA, 16'h1, reset delta, zero-extended or truncated to W.
- SHL, 4, left shift amount in the round function.
- SHR, 5, right shift amount in the round function.
- ROUNDS, 8'd1, reset round count.

Ports:
- clk  in  1  single clock for datapath and register port
- rst  in  1  asynchronous, active-high reset
- req  in  1  block request; accepted when req && ready
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- din  in  2W  block input; y = din[2W-1:W], x = din[W-1:0]
- ready  out  1  engine idle, can accept
- done  out  1  one-cycle pulse, dout newly valid
- dout  out  2W  result {y,x}; held until the next completion
- psel  in  1  register select
- penable  in  1  access phase
- pwrite  in  1  write
- paddr  in  8  byte address
- pwdata  in  32  write data
- prdata  out  32  read data, registered
- pready  out  1  tied 1

Behaviour:
- Reset (rst high, asynchronous):
  - ready=1, done=0, dout=0, prdata=0, round counter=0.
  - k0..k3=KEY, delta=DELTA, rounds=ROUNDS, err=0.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- Round function: F(v,ka,kb,s) = ((v<<SHL)+ka) ^ (v+s) ^ ((v>>SHR)+kb). All arithmetic is modulo 2^W.
- Accept (cycle 0, req && ready):
  - Latch x, y and mode.
  - Snapshot k0..k3, delta, rounds into working copies.
  - cnt=rounds; ready drops next cycle.
  - Initial sum: 0 for encrypt; (delta*rounds) mod 2^W for decrypt (W-bit multiply result, truncated).
- Encrypt round (one per cycle while cnt!=0):
  - sum+=delta
  - x+=F(y,k0,k1,sum_new)
  - y+=F(x_new,k2,k3,sum_new)
  - cnt-=1
- Decrypt round (one per cycle while cnt!=0):
  - y-=F(x,k2,k3,sum)
  - x-=F(y_new,k0,k1,sum)
  - sum-=delta
  - cnt-=1
- Completion:
  - In the cycle after the last round: dout={y,x}, done=1, ready=1.
  - Latency accept→done = rounds+1 cycles.
  - The next accept may occur in the done cycle.
- rounds=0: pass-through; done one cycle after accept with dout=din.
- Back-to-back: req held high gives one block per rounds+1 cycles. req while busy is ignored and never queued.
- mode and din changes while busy have no effect.
- FSM: IDLE (ready=1) → RUN on accept (or → DONE if rounds=0); RUN → DONE when cnt reaches 1 and that round executes; DONE → IDLE, or DONE → RUN/DONE on a same-cycle accept.
- Register map (word addresses; low W bits used; reads zero-extended):
  - 0x00 k0, 0x04 k1, 0x08 k2, 0x0C k3 (RW)
  - 0x10 delta (RW)
  - 0x14 rounds [7:0] (RW)
  - 0x18 status (RO): [0]=busy (~ready), [1]=err
  - Unmapped addresses read 0; writes to them are ignored.
- Register access:
  - Write occurs on psel && penable && pwrite.
  - prdata updates on psel && ~penable.
  - A write to 0x00–0x14 while busy is dropped and sets err.
  - A status read clears err after the read data is captured. If a read clear and a new error land in the same cycle, the set wins.
  - A write in the same cycle as an accept is applied; the accept snapshots the pre-write value.

Decomposition:
- Package tinycrypt_pkg:
  - Register address constants.
  - Status bit positions.
  - FSM state enum (IDLE, RUN, DONE).
  - Mode encoding constants.
- Sub-module tinycrypt_round: combinational single-round datapath, parametrised on W/SHL/SHR. Inputs x, y, sum, delta, keys, mode; outputs x', y', sum'.
- Top holds the FSM, counter, snapshots and register file.

Test Plan:
- Defaults (W=16, rounds=1), write k0..k3=0, delta=1; encrypt din=32'h0000_0000 → done after 2 cycles, dout=32'h0012_0001.
- Same config; decrypt din=32'h0012_0001 → dout=32'h0000_0000. Then rounds=32, random key/delta, 100 random blocks encrypt-then-decrypt → original block returned, each latency 33 cycles.
- rounds=0; encrypt din=32'hDEAD_BEEF → dout=32'hDEAD_BEEF one cycle after accept; ready never observed low beyond that cycle.
- rounds=8; write k0=16'h1234 while busy → k0 unchanged, status reads 0x3 then 0x0 (or 0x1 if still busy); result matches a golden model using the old key.
- req held high with 3 queued blocks, rounds=4 → accepts at cycles 0, 5, 10; done at cycles 5, 10, 15.
- Assert rst at cycle 3 of an 8-round op → no done, ready=1, dout=0, k0 back to 16'h4da3, delta back to 1. W=8 and W=32 builds repeat the round-trip scenario.
